alu_core: RTL and testbench
===========================

# alu_core

Parametrised, handshaked successor to the combinational 4-bit ALU. Operand width is set by `WIDTH`, and carry/borrow are held in an internal flag register instead of being fed in. The block adds multi-cycle multiply and variable-distance shifts. It sits between the decode/operand-fetch stage and register write-back, using valid/ready on both sides.

## Interface
- `WIDTH`, default 4: operand and result width, ≥2.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operation request.
- `in_ready` out 1: block can accept a request this cycle.
- `a`, `b` in `WIDTH`: operands, sampled only on accept.
- `mode` in 4: opcode, sampled on accept.
- `out_valid` out 1: `c`/`flags` hold a result.
- `out_ready` in 1: consumer takes the result.
- `c` out `WIDTH`: result register.
- `flags` out 4: [0] carry, [1] borrow, [2] zero, [3] a<b unsigned.

## Operation
- Opcodes:
  - 0000 ADD, 0001 ADC (+flags[0]), 0010 SUB, 0011 SBB (−flags[1]).
  - 0100 SHL1, 0101 SHR1, 0110 AND, 0111 OR, 1000 NOT a, 1001 XOR, 1010 NAND, 1011 NOR.
  - 1100 MUL: low `WIDTH` bits of a*b, shift-add.
  - 1101 SHLN: a<<b. 1110 SHRN: a>>b, logical.
  - 1111 CLF: c=0, clears flags[0] and flags[1].
- Accept means `in_valid && in_ready` at a clock edge. `a`, `b` and `mode` are latched then; later input changes are ignored.
- FSM states:
  - IDLE: `in_ready`=1.
  - RUN: iterative ops, counter `cnt`.
  - HOLD: `out_valid`=1.
- Transitions:
  - Accept of opcode 0000–1011 or 1111 → HOLD.
  - Accept of MUL → RUN with cnt=`WIDTH`.
  - Accept of SHLN/SHRN → RUN with cnt=min(b,`WIDTH`). If that is 0, go straight to HOLD with c=a.
  - RUN decrements `cnt` each cycle, shifting one bit (or doing one add-step) per cycle. Entering HOLD follows the cycle where cnt reaches 1.
  - HOLD with `out_ready`=1 → IDLE. If a new accept happens in the same cycle, take that accept's path directly.
- `in_ready` = (state==IDLE) || (state==HOLD && `out_ready`). It is combinational from state and `out_ready`.
- Flags update once, on entry to HOLD:
  - zero = (c==0). lt = latched a < latched b, unsigned.
  - carry: written by ADD/ADC (carry-out), MUL (high half of product ≠0), SHL1/SHLN (any 1 shifted out). Otherwise kept.
  - borrow: written by SUB/SBB (borrow-out). Otherwise kept.
  - CLF clears both carry and borrow.
- ADC/SBB use the flags register value at the accept edge. Back-to-back chaining through HOLD→accept therefore sees the previous op's carry/borrow.
- Arithmetic is modulo 2^`WIDTH`, and shift distances ≥`WIDTH` give 0. Only the low `WIDTH` bits of a product are kept.

## Timing
- Reset: state IDLE, `c`=0, `flags`=0, `out_valid`=0, `in_ready`=1, `cnt`=0.
- Latency from accept edge to `out_valid` high:
  - Single-cycle ops and zero-distance shifts: 1 cycle.
  - MUL: `WIDTH`+1 cycles.
  - Shifts: min(b,`WIDTH`)+1 cycles.
- Throughput for single-cycle ops is 1 per cycle while `out_ready`=1.
- With `out_ready`=0 in HOLD, `c`, `flags` and `out_valid` are stable and `in_ready`=0.
- `rst` during RUN or HOLD aborts the op. No result is produced and flags are cleared.

## Structure
- Package `alu_pkg` holds:
  - `MODE_*` localparams for all 16 opcodes.
  - `FLAG_CARRY`/`FLAG_BORROW`/`FLAG_ZERO`/`FLAG_LT` bit indices.
  - The FSM state enum (IDLE/RUN/HOLD).
- One sub-module, `alu_logic`, is combinational and parametrised by `WIDTH`. It computes the single-cycle results plus carry/borrow-out.
- `alu_core` owns the FSM, the iterative multiply/shift datapath and the flag register.

## Test plan
All cases use WIDTH=4.
- **ADD/ADC chain:** ADD 9+8 → c=1, flags[0]=1, `out_valid` 1 cycle after accept. Then ADC 1+2 → c=4, flags[0]=0.
- **SUB/SBB chain:** SUB 3−5 → c=0xE, flags[1]=1, flags[3]=1. Then SBB 7−2 → c=4, flags[1]=0, flags[2]=0.
- **MUL:** 5*3 → c=0xF, carry=0, `out_valid` at cycle 5 after accept. Then 6*3 → c=2, carry=1. Then 0*9 → zero=1.
- **Shifts:**
  - SHLN a=0011, b=2 → c=1100 at cycle 3, carry=0.
  - SHLN a=0011, b=7 → c=0, carry=1, cycle 5.
  - SHRN b=0 → c=a at cycle 1.
- **Backpressure:** hold `out_ready`=0 for 3 cycles → `c`/`flags` stable and `in_ready`=0. Then raise `out_ready` with a new `in_valid` → same-cycle accept, and the next result appears 1 cycle later.
- **Reset and CLF:**
  - Assert `rst` in cycle 2 of a MUL → `out_valid` never rises, `flags`=0, `in_ready`=1 next cycle.
  - CLF after a carry-setting ADD → flags[1:0]=00, c=0, zero=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM state encoding for the ALU core.
package alu_pkg;

  localparam logic [3:0] MODE_ADD  = 4'b0000;
  localparam logic [3:0] MODE_ADC  = 4'b0001;
  localparam logic [3:0] MODE_SUB  = 4'b0010;
  localparam logic [3:0] MODE_SBB  = 4'b0011;
  localparam logic [3:0] MODE_SHL1 = 4'b0100;
  localparam logic [3:0] MODE_SHR1 = 4'b0101;
  localparam logic [3:0] MODE_AND  = 4'b0110;
  localparam logic [3:0] MODE_OR   = 4'b0111;
  localparam logic [3:0] MODE_NOT  = 4'b1000;
  localparam logic [3:0] MODE_XOR  = 4'b1001;
  localparam logic [3:0] MODE_NAND = 4'b1010;
  localparam logic [3:0] MODE_NOR  = 4'b1011;
  localparam logic [3:0] MODE_MUL  = 4'b1100;
  localparam logic [3:0] MODE_SHLN = 4'b1101;
  localparam logic [3:0] MODE_SHRN = 4'b1110;
  localparam logic [3:0] MODE_CLF  = 4'b1111;

  localparam int FLAG_CARRY  = 0;
  localparam int FLAG_BORROW = 1;
  localparam int FLAG_ZERO   = 2;
  localparam int FLAG_LT     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/alu_logic.sv
// Single-cycle ALU results with carry/borrow-out; iterative opcodes pass a through.
module alu_logic
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       mode_i,
  input  logic             carry_i,
  input  logic             borrow_i,
  output logic [WIDTH-1:0] y_o,
  output logic             carry_o,
  output logic             borrow_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  always_comb begin
    sum      = {1'b0, a_i} + {1'b0, b_i}
             + {{WIDTH{1'b0}}, (mode_i == MODE_ADC) & carry_i};
    // bit WIDTH of the extended difference is the borrow-out
    diff     = {1'b0, a_i} - {1'b0, b_i}
             - {{WIDTH{1'b0}}, (mode_i == MODE_SBB) & borrow_i};
    y_o      = a_i;
    carry_o  = 1'b0;
    borrow_o = 1'b0;
    case (mode_i)
      MODE_ADD, MODE_ADC: begin
        y_o     = sum[WIDTH-1:0];
        carry_o = sum[WIDTH];
      end
      MODE_SUB, MODE_SBB: begin
        y_o      = diff[WIDTH-1:0];
        borrow_o = diff[WIDTH];
      end
      MODE_SHL1: begin
        y_o     = {a_i[WIDTH-2:0], 1'b0};
        carry_o = a_i[WIDTH-1];
      end
      MODE_SHR1: y_o = {1'b0, a_i[WIDTH-1:1]};
      MODE_AND:  y_o = a_i & b_i;
      MODE_OR:   y_o = a_i | b_i;
      MODE_NOT:  y_o = ~a_i;
      MODE_XOR:  y_o = a_i ^ b_i;
      MODE_NAND: y_o = ~(a_i & b_i);
      MODE_NOR:  y_o = ~(a_i | b_i);
      MODE_CLF:  y_o = '0;
      default:   y_o = a_i;
    endcase
  end

endmodule

// File: rtl/alu_core.sv
// Handshaked ALU: IDLE/RUN/HOLD FSM, iterative multiply and shift datapath, flag register.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic [3:0]       flags
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   c_q, c_d;
  logic [3:0]         flags_q, flags_d;
  logic [3:0]         op_q, op_d;
  logic               lt_q, lt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               sh_out_q, sh_out_d;

  logic               accept;
  logic [WIDTH-1:0]   logic_y;
  logic               logic_carry, logic_borrow;
  logic               go_hold, wr_carry, wr_borrow, clr_cb;
  logic [WIDTH-1:0]   res_c, sh;
  logic               res_carry, res_borrow, res_lt, sh_any;
  logic [2*WIDTH-1:0] prod;

  alu_logic #(.WIDTH(WIDTH)) u_logic (
    .a_i      (a),
    .b_i      (b),
    .mode_i   (mode),
    .carry_i  (flags_q[FLAG_CARRY]),
    .borrow_i (flags_q[FLAG_BORROW]),
    .y_o      (logic_y),
    .carry_o  (logic_carry),
    .borrow_o (logic_borrow)
  );

  assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);
  assign c         = c_q;
  assign flags     = flags_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    c_d        = c_q;
    flags_d    = flags_q;
    op_d       = op_q;
    lt_d       = lt_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    sh_out_d   = sh_out_q;
    go_hold    = 1'b0;
    wr_carry   = 1'b0;
    wr_borrow  = 1'b0;
    clr_cb     = 1'b0;
    res_c      = '0;
    res_carry  = 1'b0;
    res_borrow = 1'b0;
    res_lt     = lt_q;
    prod       = acc_q + (mplier_q[0] ? mcand_q : '0);
    sh         = '0;
    sh_any     = 1'b0;

    if ((state_q == HOLD) && out_ready) state_d = IDLE;

    // one multiply add-step or one single-bit shift per RUN cycle
    if (state_q == RUN) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (op_q == MODE_MUL) begin
        acc_d     = prod;
        mcand_d   = mcand_q << 1;
        mplier_d  = mplier_q >> 1;
        res_c     = prod[WIDTH-1:0];
        res_carry = |prod[2*WIDTH-1:WIDTH];
        wr_carry  = 1'b1;
      end else if (op_q == MODE_SHLN) begin
        sh        = acc_q[WIDTH-1:0] << 1;
        sh_any    = sh_out_q | acc_q[WIDTH-1];
        acc_d     = {{WIDTH{1'b0}}, sh};
        sh_out_d  = sh_any;
        res_c     = sh;
        res_carry = sh_any;
        wr_carry  = 1'b1;
      end else begin
        sh    = acc_q[WIDTH-1:0] >> 1;
        acc_d = {{WIDTH{1'b0}}, sh};
        res_c = sh;
      end
      if (cnt_q == CNT_W'(1)) go_hold = 1'b1;
    end

    if (accept) begin
      op_d   = mode;
      lt_d   = (a < b);
      res_lt = (a < b);
      if (mode == MODE_MUL) begin
        state_d  = RUN;
        cnt_d    = CNT_W'(WIDTH);
        acc_d    = '0;
        mcand_d  = {{WIDTH{1'b0}}, a};
        mplier_d = b;
      end else if ((mode == MODE_SHLN) || (mode == MODE_SHRN)) begin
        acc_d    = {{WIDTH{1'b0}}, a};
        sh_out_d = 1'b0;
        if (b == '0) begin
          go_hold  = 1'b1;
          res_c    = a;
          wr_carry = (mode == MODE_SHLN);
        end else begin
          state_d = RUN;
          cnt_d   = (int'(b) >= WIDTH) ? CNT_W'(WIDTH) : CNT_W'(b);
        end
      end else begin
        go_hold    = 1'b1;
        res_c      = logic_y;
        res_carry  = logic_carry;
        res_borrow = logic_borrow;
        wr_carry   = (mode == MODE_ADD) || (mode == MODE_ADC) || (mode == MODE_SHL1);
        wr_borrow  = (mode == MODE_SUB) || (mode == MODE_SBB);
        clr_cb     = (mode == MODE_CLF);
      end
    end

    // flags and result register change only on entry to HOLD
    if (go_hold) begin
      state_d            = HOLD;
      c_d                = res_c;
      flags_d[FLAG_ZERO] = (res_c == '0);
      flags_d[FLAG_LT]   = res_lt;
      if (wr_carry)  flags_d[FLAG_CARRY]  = res_carry;
      if (wr_borrow) flags_d[FLAG_BORROW] = res_borrow;
      if (clr_cb) begin
        flags_d[FLAG_CARRY]  = 1'b0;
        flags_d[FLAG_BORROW] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      c_q     <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      flags_q <= flags_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q     <= op_d;
    lt_q     <= lt_d;
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    sh_out_q <= sh_out_d;
  end

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core (WIDTH=4): reference model, latency, backpressure and reset abort.
module tb_alu_core;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a, b, mode;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] c;
  logic [3:0] flags;

  typedef struct {
    logic [3:0] c;
    logic [3:0] f;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] mflags = 4'h0;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic       pv = 1'b0, pr = 1'b0;

  alu_core #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .flags     (flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [3:0] m, input int av, input int bv,
                                 input logic [3:0] f);
    exp_t e;
    int r;
    logic [3:0] nf;
    nf = f;
    r  = 0;
    case (m)
      4'h0: begin r = av + bv;              nf[0] = (r > 15); end
      4'h1: begin r = av + bv + int'(f[0]); nf[0] = (r > 15); end
      4'h2: begin r = av - bv;              nf[1] = (r < 0);  end
      4'h3: begin r = av - bv - int'(f[1]); nf[1] = (r < 0);  end
      4'h4: begin r = av * 2;               nf[0] = (r > 15); end
      4'h5: r = av / 2;
      4'h6: r = av & bv;
      4'h7: r = av | bv;
      4'h8: r = ~av;
      4'h9: r = av ^ bv;
      4'hA: r = ~(av & bv);
      4'hB: r = ~(av | bv);
      4'hC: begin r = av * bv;  nf[0] = (r > 15); end
      4'hD: begin r = av << bv; nf[0] = ((r >> 4) != 0); end
      4'hE: r = av >> bv;
      default: begin r = 0; nf[1:0] = 2'b00; end
    endcase
    e.c   = 4'(r & 15);
    nf[2] = (e.c == 4'h0);
    nf[3] = (av < bv);
    e.f   = nf;
    e.cyc = 0;
    return e;
  endfunction

  function automatic int lat(input logic [3:0] m, input int bv);
    if (m == MODE_MUL) return 5;
    if ((m == MODE_SHLN) || (m == MODE_SHRN)) return ((bv > 4) ? 4 : bv) + 1;
    return 1;
  endfunction

  // Call right after a rising edge; returns 1 time unit after the accepting edge.
  task automatic send(input logic [3:0] m, input int av, input int bv);
    exp_t e;
    int   n;
    n        = 0;
    in_valid = 1'b1;
    mode     = m;
    a        = 4'(av);
    b        = 4'(bv);
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      e      = model(m, av, bv, mflags);
      e.cyc  = cyc + lat(m, bv);
      mflags = e.f;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 4'($urandom_range(0, 15));
    b        = 4'($urandom_range(0, 15));
    mode     = 4'($urandom_range(0, 15));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && (!pv || pr)) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("c", 32'(c), 32'(e.c));
        chk("flags", 32'(flags), 32'(e.f));
        chk("latency_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    pv = out_valid;
    pr = out_ready;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t tmp;
    logic seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = 4'h0;
    b         = 4'h0;
    mode      = 4'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_c", 32'(c), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    @(posedge clk);
    #1;

    // carry chain, borrow chain, back-to-back
    send(MODE_ADD, 9, 8);
    send(MODE_ADC, 1, 2);
    send(MODE_SUB, 3, 5);
    send(MODE_SBB, 7, 2);
    drain();

    send(MODE_MUL, 5, 3);
    send(MODE_MUL, 6, 3);
    send(MODE_MUL, 0, 9);
    drain();

    send(MODE_SHLN, 3, 2);
    send(MODE_SHLN, 3, 7);
    send(MODE_SHRN, 10, 0);
    send(MODE_SHRN, 12, 3);
    send(MODE_SHLN, 9, 0);
    drain();

    // backpressure: result and flags must stay put while the consumer stalls
    out_ready = 1'b0;
    send(MODE_ADD, 6, 7);
    @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("bp_c", 32'(c), 32'hD);
      chk("bp_flags", 32'(flags), 32'(mflags));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(MODE_XOR, 5, 3);
    send(MODE_SUB, 3, 5);
    drain();

    // reset in the second cycle of a multiply aborts it and clears flags
    send(MODE_MUL, 7, 7);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    tmp    = sb.pop_back();
    mflags = 4'h0;
    @(negedge clk);
    chk("abort_flags", 32'(flags), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_result", 32'(seen), 32'd0);
    @(posedge clk);
    #1;

    send(MODE_ADD, 9, 8);
    send(MODE_CLF, 4, 1);
    drain();

    for (int i = 0; i < 40; i++) begin
      send(4'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
